pc_sel_unit: RTL and testbench
==============================

# pc_sel_unit

Parametrised program-counter register and next-PC selector for the fetch stage. Each cycle it chooses among the sequential address, branch target, jump-register target and exception vector, and holds the PC during pipeline stalls. A redirect that arrives while the PC is stalled is buffered in a one-entry pending slot and applied when the stall releases. It supplies the fetch address `Pc` and the sequential successor `Npc` to the rest of the pipeline.

## Interface

Parameters:

- `WIDTH`, 16, PC and address width in bits
- `INC`, 1, sequential increment (word-addressed memory)
- `RESET_PC`, 0, value loaded into `Pc` on reset
- `EXC_VECTOR`, 16'h0004 (WIDTH bits), exception/interrupt entry address

Ports:

- `Clk`  in  1  clock; all state updates on the rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `Stall`  in  1  hold `Pc`; sequential advance is suppressed
- `BrTaken`  in  1  conditional branch resolved as taken
- `BrTarget`  in  WIDTH  branch target address
- `JrValid`  in  1  jump-register / indirect jump valid
- `JrTarget`  in  WIDTH  jump-register target address
- `ExcReq`  in  1  exception or interrupt request
- `Pc`  out  WIDTH  current fetch address (registered)
- `Npc`  out  WIDTH  `Pc + INC` (combinational from `Pc`)
- `PendValid`  out  1  a redirect is held in the pending slot (registered)
- `Redirected`  out  1  one-cycle pulse; `Pc` was loaded from a non-sequential source on the last edge (registered)

## Operation

- State:
  - `Pc` register.
  - Pending slot: `PendValid` plus a `PendTarget` register of WIDTH bits.
  - `Redirected` register.
- Live redirect priority: `ExcReq` > `JrValid` > `BrTaken`.
- Each rising edge, when `Rst`=0, the first matching rule applies:
  1. `ExcReq`=1, regardless of `Stall`: `Pc`←`EXC_VECTOR`, `PendValid`←0, `Redirected`←1.
  2. `Stall`=1 with `JrValid` or `BrTaken` asserted:
     - `Pc` is held; `Redirected`←0.
     - If `PendValid`=0: capture the highest-priority live target into `PendTarget`; `PendValid`←1.
     - If `PendValid`=1: keep the existing entry, because the first-captured redirect is the oldest.
  3. `Stall`=1, no redirect: hold all state; `Redirected`←0.
  4. `Stall`=0 and `PendValid`=1:
     - `Pc`←`PendTarget`; `PendValid`←0; `Redirected`←1.
     - Live `JrValid`/`BrTaken` in this cycle are discarded. The redirect flushes their source stage.
  5. `Stall`=0, `JrValid`=1: `Pc`←`JrTarget`; `Redirected`←1.
  6. `Stall`=0, `BrTaken`=1: `Pc`←`BrTarget`; `Redirected`←1.
  7. Otherwise: `Pc`←`Npc`; `Redirected`←0.
- Arithmetic:
  - `Npc` = (`Pc` + `INC`) mod 2^WIDTH. Overflow wraps silently, e.g. 16'hFFFF → 16'h0000.
  - Targets are taken verbatim; there is no alignment check.
- Reset (`Rst`=1 at an edge) overrides all other inputs, including `ExcReq`:
  - `Pc`←`RESET_PC`, `PendValid`←0, `PendTarget`←0, `Redirected`←0.
  - Reset in the middle of a stall with a pending redirect discards the pending entry.

## Timing

- Inputs are sampled on the rising edge. The new `Pc` is visible one cycle after the redirect is asserted; redirect latency is 1 cycle.
- `Redirected` is high in exactly the cycle in which the redirected `Pc` is first visible. It is never high during a held cycle.
- A buffered redirect costs 1 cycle after `Stall` falls. At the edge where `Stall`=0 is sampled, `Pc` takes `PendTarget`.
- `Npc` follows `Pc` combinationally within the same cycle.
- In the first cycle after reset is released: `Pc`=`RESET_PC`, `Npc`=`RESET_PC`+`INC`, `PendValid`=0, `Redirected`=0.
- `Stall` held for N cycles with no redirect: `Pc` is constant for N cycles, then advances by `INC`.

## Test plan

- **Reset and sequential run:** assert `Rst` for 2 cycles, then run free for 4 cycles. Required: `Pc` = 0, 1, 2, 3, 4; `Npc` is always `Pc`+1; `Redirected`=0.
- **Branch vs jump priority:** at `Pc`=5, drive `BrTaken`=1 with `BrTarget`=16'h0040 and `JrValid`=1 with `JrTarget`=16'h0080 for one cycle. Required: next `Pc`=16'h0080 with `Redirected`=1 for 1 cycle; the following `Pc`=16'h0081.
- **Stalled redirect buffering:**
  - Raise `Stall` at `Pc`=16'h0010 for 3 cycles.
  - In the first stall cycle drive `BrTaken` with `BrTarget`=16'h0100; in the second drive `BrTarget`=16'h0200.
  - Required: `Pc` holds at 16'h0010 and `PendValid`=1 from the cycle after capture.
  - Required: after release, `Pc`=16'h0100 (the first-captured target), `PendValid`=0, `Redirected`=1.
- **Exception overrides stall and pending:** with `Stall`=1 and `PendValid`=1 (`PendTarget`=16'h0100), pulse `ExcReq`. Required: next `Pc`=`EXC_VECTOR`=16'h0004, `PendValid`=0, `Redirected`=1.
- **Wrap and reset mid-operation:**
  - Load `Pc`=16'hFFFF via `JrTarget`. Required: next `Pc`=16'h0000 and `Npc`=16'h0001.
  - Then stall with a pending branch and assert `Rst`. Required: `Pc`=`RESET_PC`, `PendValid`=0; after reset is released, no stale redirect is applied.
- **Parametrisation:** repeat the sequential-run and wrap checks with `WIDTH`=32, `INC`=4, `RESET_PC`=32'hBFC00000. Required: `Pc` steps 32'hBFC00000 → 32'hBFC00004 → …; 32'hFFFFFFFC wraps to 32'h00000000.

Source files
------------

// File: rtl/pc_sel_unit.sv
// Fetch-stage program counter with next-PC selection and a one-entry slot that
// holds a redirect arriving during a stall until the stall releases.
module pc_sel_unit #(
  parameter int unsigned     WIDTH      = 16,
  parameter int unsigned     INC        = 1,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(4)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             BrTaken,
  input  logic [WIDTH-1:0] BrTarget,
  input  logic             JrValid,
  input  logic [WIDTH-1:0] JrTarget,
  input  logic             ExcReq,
  output logic [WIDTH-1:0] Pc,
  output logic [WIDTH-1:0] Npc,
  output logic             PendValid,
  output logic             Redirected
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             redir_q, redir_d;
  logic [WIDTH-1:0] live_target;
  logic             live_redir;

  assign Npc         = pc_q + WIDTH'(INC);
  assign live_redir  = JrValid | BrTaken;
  assign live_target = JrValid ? JrTarget : BrTarget;

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    redir_d       = 1'b0;
    if (ExcReq) begin
      pc_d         = EXC_VECTOR;
      pend_valid_d = 1'b0;
      redir_d      = 1'b1;
    end else if (Stall) begin
      // Only the oldest redirect is kept; later ones come from a flushed path.
      if (live_redir && !pend_valid_q) begin
        pend_target_d = live_target;
        pend_valid_d  = 1'b1;
      end
    end else if (pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
      redir_d      = 1'b1;
    end else if (live_redir) begin
      pc_d    = live_target;
      redir_d = 1'b1;
    end else begin
      pc_d = Npc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      redir_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      redir_q       <= redir_d;
    end
  end

  assign Pc         = pc_q;
  assign PendValid  = pend_valid_q;
  assign Redirected = redir_q;

endmodule

// File: tb/tb_pc_sel_unit.sv
// Scoreboard bench for pc_sel_unit: directed and random stimulus against a
// rule-level model, plus a 32-bit instance for the parametrised checks.
module tb_pc_sel_unit;

  logic        Clk = 1'b0;
  logic        Rst, Stall, BrTaken, JrValid, ExcReq;
  logic [15:0] BrTarget, JrTarget, Pc, Npc;
  logic        PendValid, Redirected;

  logic        Rst2, Stall2, BrTaken2, JrValid2, ExcReq2;
  logic [31:0] BrTarget2, JrTarget2, Pc2, Npc2;
  logic        PendValid2, Redirected2;

  always #5 Clk = ~Clk;

  pc_sel_unit dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BrTaken(BrTaken), .BrTarget(BrTarget),
    .JrValid(JrValid), .JrTarget(JrTarget), .ExcReq(ExcReq), .Pc(Pc), .Npc(Npc),
    .PendValid(PendValid), .Redirected(Redirected)
  );

  pc_sel_unit #(
    .WIDTH(32), .INC(4), .RESET_PC(32'hBFC0_0000), .EXC_VECTOR(32'h0000_0004)
  ) dut32 (
    .Clk(Clk), .Rst(Rst2), .Stall(Stall2), .BrTaken(BrTaken2), .BrTarget(BrTarget2),
    .JrValid(JrValid2), .JrTarget(JrTarget2), .ExcReq(ExcReq2), .Pc(Pc2), .Npc(Npc2),
    .PendValid(PendValid2), .Redirected(Redirected2)
  );

  typedef struct {
    logic [15:0] pc;
    logic        pend;
    logic        redir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b1;

  // Reference model state: the pending slot is a queue holding at most one target.
  logic [15:0] m_pc;
  logic [15:0] m_slot[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Apply inputs for one edge, advance the model by the rules, queue the result.
  task automatic step(input logic rst, input logic stall, input logic br,
                      input logic [15:0] brt, input logic jr, input logic [15:0] jrt,
                      input logic exc);
    exp_t e;
    Rst = rst; Stall = stall; BrTaken = br; BrTarget = brt;
    JrValid = jr; JrTarget = jrt; ExcReq = exc;
    e.redir = 1'b0;
    if (rst) begin
      m_pc = 16'h0000;
      m_slot.delete();
    end else if (exc) begin
      m_pc = 16'h0004;
      m_slot.delete();
      e.redir = 1'b1;
    end else if (stall) begin
      if ((jr || br) && m_slot.size() == 0) m_slot.push_back(jr ? jrt : brt);
    end else if (m_slot.size() != 0) begin
      m_pc = m_slot.pop_front();
      e.redir = 1'b1;
    end else if (jr) begin
      m_pc = jrt;
      e.redir = 1'b1;
    end else if (br) begin
      m_pc = brt;
      e.redir = 1'b1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
    e.pc   = m_pc;
    e.pend = (m_slot.size() != 0);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input logic stall);
    step(1'b0, stall, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a state; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (mon_en && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pc", 64'(Pc), 64'(e.pc));
        chk("npc", 64'(Npc), 64'(16'(e.pc + 16'd1)));
        chk("pend_valid", 64'(PendValid), 64'(e.pend));
        chk("redirected", 64'(Redirected), 64'(e.redir));
      end
    end
  end

  initial begin
    Rst2 = 1'b1; Stall2 = 1'b0; BrTaken2 = 1'b0; BrTarget2 = '0;
    JrValid2 = 1'b0; JrTarget2 = '0; ExcReq2 = 1'b0;

    // Reset and free run: 0,1,2,3,4 then 5.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    repeat (5) idle(1'b0);
    // Jump beats branch.
    step(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0);
    idle(1'b0);
    // Stalled redirect buffering at 0x0010; first target wins.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    // Exception overrides stall and pending slot.
    step(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle(1'b0);
    // Wrap, then reset during a stall with a pending branch.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 5) == 0, 16'($urandom),
           $urandom_range(0, 19) == 0);
    end
    idle(1'b0);

    repeat (4) begin
      if (sb_q.size() != 0) @(negedge Clk);
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    mon_en = 1'b0;

    // 32-bit instance: reset, sequential run, wrap.
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst2 = 1'b0;
    @(negedge Clk);
    chk("pc32_reset", 64'(Pc2), 64'h0000_0000_BFC0_0000);
    chk("npc32_reset", 64'(Npc2), 64'h0000_0000_BFC0_0004);
    chk("pend32_reset", 64'(PendValid2), 64'd0);
    @(negedge Clk);
    chk("pc32_seq1", 64'(Pc2), 64'h0000_0000_BFC0_0004);
    @(negedge Clk);
    chk("pc32_seq2", 64'(Pc2), 64'h0000_0000_BFC0_0008);
    chk("redir32_seq", 64'(Redirected2), 64'd0);
    JrValid2 = 1'b1; JrTarget2 = 32'hFFFF_FFFC;
    @(posedge Clk); #1;
    JrValid2 = 1'b0;
    @(negedge Clk);
    chk("pc32_jr", 64'(Pc2), 64'h0000_0000_FFFF_FFFC);
    chk("redir32_jr", 64'(Redirected2), 64'd1);
    chk("npc32_wrap", 64'(Npc2), 64'd0);
    @(negedge Clk);
    chk("pc32_wrap", 64'(Pc2), 64'd0);
    chk("npc32_after_wrap", 64'(Npc2), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
